// File: rtl/rs232_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rs232_pkg : shared parity encodings, FSM states and clogb2 helper    |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
package rs232_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } rs232_state_e;

  // Ceiling log2, never less than 1 so every counter has at least one bit.
  function automatic int clogb2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rs232_os_tick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rs232_os_tick : oversample tick divider with synchronous restart     |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module rs232_os_tick
  import rs232_pkg::*;
#(
  parameter int P_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic os_tick
);

  localparam int CNT_W = clogb2(P_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    os_tick = 1'b0;
    cnt_d   = cnt_q + 1'b1;
    if (restart) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      os_tick = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule
`default_nettype wire

// File: rtl/rs232_des_os.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rs232_des_os : oversampling RS-232 receiver with majority vote and   |
// |                parity/framing/overrun/break reporting                |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module rs232_des_os
  import rs232_pkg::*;
#(
  parameter int P_CLK_FREQ_HZ = 100000000,
  parameter int P_BAUD_RATE   = 115200,
  parameter int P_OVERSAMPLE  = 16,
  parameter int P_DATA_BITS   = 8,
  parameter int P_PARITY      = 0,
  parameter int P_STOP_BITS   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx,
  output logic [P_DATA_BITS-1:0] rx_fifo_data,
  output logic                   rx_fifo_wr_en,
  input  logic                   rx_fifo_full,
  output logic                   parity_err,
  output logic                   frame_err,
  output logic                   overrun,
  output logic                   break_det
);

  localparam int DIV_RAW = P_CLK_FREQ_HZ / (P_BAUD_RATE * P_OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int OS_W    = clogb2(P_OVERSAMPLE);
  localparam int BIT_W   = clogb2(P_DATA_BITS + 1);
  localparam int M       = P_OVERSAMPLE / 2;

  localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(P_OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  VOTE_A    = OS_W'(M - 1);
  localparam logic [OS_W-1:0]  VOTE_B    = OS_W'(M);
  localparam logic [OS_W-1:0]  VOTE_C    = OS_W'(M + 1);
  localparam logic [BIT_W-1:0] BITS_LAST = BIT_W'(P_DATA_BITS);
  localparam logic             STOP_LAST = (P_STOP_BITS == 2);

  if (P_DATA_BITS < 5 || P_DATA_BITS > 9 || P_STOP_BITS < 1 || P_STOP_BITS > 2 ||
      P_OVERSAMPLE < 8 || (P_OVERSAMPLE % 2) != 0 || P_PARITY < 0 || P_PARITY > 2)
  begin : g_bad_params
    $error("rs232_des_os: illegal parameter combination");
  end

  rs232_state_e           state_q, state_d;
  logic                   sync1_q, sync1_d, rx_s_q, rx_s_d, rx_dly_q, rx_dly_d;
  logic [OS_W-1:0]        os_cnt_q, os_cnt_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                   stop_cnt_q, stop_cnt_d;
  logic [1:0]             vote_q, vote_d;
  logic [P_DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic                   par_bit_q, par_bit_d, frame_q, frame_d;
  logic                   wr_en_q, wr_en_d, parity_err_q, parity_err_d;
  logic                   frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic                   break_q, break_d;

  logic os_tick, restart, maj, mid_tick, bit_end, par_bad, frame_now;

  rs232_os_tick #(.P_DIV(DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .os_tick (os_tick)
  );

  always_comb begin
    sync1_d      = rx;
    rx_s_d       = sync1_q;
    rx_dly_d     = rx_s_q;
    state_d      = state_q;
    os_cnt_d     = os_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    vote_d       = vote_q;
    shift_d      = shift_q;
    data_d       = data_q;
    par_bit_d    = par_bit_q;
    frame_d      = frame_q;
    wr_en_d      = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
    break_d      = 1'b0;
    restart      = 1'b0;

    // Third vote is the live synchronised sample taken on the deciding tick.
    maj       = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s_q) | (vote_q[1] & rx_s_q);
    mid_tick  = os_tick && (os_cnt_q == VOTE_C);
    bit_end   = os_tick && (os_cnt_q == OS_LAST);
    frame_now = frame_q | ~maj;
    if (P_PARITY == PAR_NONE) par_bad = 1'b0;
    else if (P_PARITY == PAR_ODD) par_bad = ~(^shift_q ^ par_bit_q);
    else par_bad = ^shift_q ^ par_bit_q;

    if (state_q != S_IDLE && state_q != S_BREAK && os_tick) begin
      os_cnt_d = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + 1'b1;
      if (os_cnt_q == VOTE_A) vote_d[0] = rx_s_q;
      if (os_cnt_q == VOTE_B) vote_d[1] = rx_s_q;
    end

    case (state_q)
      S_IDLE: begin
        if (rx_dly_q && !rx_s_q) begin
          restart  = 1'b1;
          os_cnt_d = '0;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (mid_tick && maj) begin
          state_d = S_IDLE;
        end else if (bit_end) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (mid_tick) begin
          shift_d   = {maj, shift_q[P_DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end else if (bit_end && bit_cnt_q == BITS_LAST) begin
          state_d    = (P_PARITY != PAR_NONE) ? S_PARITY : S_STOP;
          stop_cnt_d = 1'b0;
          frame_d    = 1'b0;
        end
      end
      S_PARITY: begin
        if (mid_tick) par_bit_d = maj;
        else if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (mid_tick) begin
          if (stop_cnt_q == STOP_LAST) begin
            // Decide on the last stop bit's mid-sample so a following start edge is not missed.
            state_d = S_IDLE;
            if (frame_now && shift_q == '0 && !par_bit_q && !maj) begin
              break_d = 1'b1;
              state_d = S_BREAK;
            end else if (frame_now) begin
              frame_err_d = 1'b1;
            end else begin
              parity_err_d = par_bad;
              if (rx_fifo_full) begin
                overrun_d = 1'b1;
              end else begin
                wr_en_d = 1'b1;
                data_d  = shift_q;
              end
            end
          end else begin
            frame_d = frame_now;
          end
        end else if (bit_end) begin
          stop_cnt_d = stop_cnt_q + 1'b1;
        end
      end
      S_BREAK: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sync1_q      <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_dly_q     <= 1'b1;
      os_cnt_q     <= '0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      vote_q       <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      par_bit_q    <= 1'b0;
      frame_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      break_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      rx_s_q       <= rx_s_d;
      rx_dly_q     <= rx_dly_d;
      os_cnt_q     <= os_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      vote_q       <= vote_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      par_bit_q    <= par_bit_d;
      frame_q      <= frame_d;
      wr_en_q      <= wr_en_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      break_q      <= break_d;
    end
  end

  assign rx_fifo_data  = data_q;
  assign rx_fifo_wr_en = wr_en_q;
  assign parity_err    = parity_err_q;
  assign frame_err     = frame_err_q;
  assign overrun       = overrun_q;
  assign break_det     = break_q;

endmodule
`default_nettype wire

// File: tb/tb_rs232_des_os.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rs232_des_os : directed bench, 8N1 and 7E1 receivers, 160 clk/bit |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
module tb_rs232_des_os;

  localparam int BIT_CLKS = 160;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx8 = 1'b1, rx7 = 1'b1;
  logic       full8 = 1'b0, full7 = 1'b0;
  logic [7:0] d8;
  logic [6:0] d7;
  logic       wr8, pe8, fe8, ov8, bk8;
  logic       wr7, pe7, fe7, ov7, bk7;

  always #5 clk = ~clk;

  rs232_des_os #(
    .P_CLK_FREQ_HZ(1600000), .P_BAUD_RATE(10000), .P_OVERSAMPLE(16),
    .P_DATA_BITS(8), .P_PARITY(0), .P_STOP_BITS(1)
  ) u_dut8 (
    .clk(clk), .rst(rst), .rx(rx8), .rx_fifo_data(d8), .rx_fifo_wr_en(wr8),
    .rx_fifo_full(full8), .parity_err(pe8), .frame_err(fe8), .overrun(ov8),
    .break_det(bk8)
  );

  rs232_des_os #(
    .P_CLK_FREQ_HZ(1600000), .P_BAUD_RATE(10000), .P_OVERSAMPLE(16),
    .P_DATA_BITS(7), .P_PARITY(2), .P_STOP_BITS(1)
  ) u_dut7 (
    .clk(clk), .rst(rst), .rx(rx7), .rx_fifo_data(d7), .rx_fifo_wr_en(wr7),
    .rx_fifo_full(full7), .parity_err(pe7), .frame_err(fe7), .overrun(ov7),
    .break_det(bk7)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event counters observed away from the active edge.
  int wr8_n = 0, pe8_n = 0, fe8_n = 0, ov8_n = 0, bk8_n = 0;
  int wr7_n = 0, pe7_wr_n = 0, err7_n = 0;
  int wr8_cyc = 0;
  logic [7:0] last8 = 8'h00, prev8 = 8'h00;
  logic [6:0] last7 = 7'h00;

  always @(negedge clk) begin
    if (wr8) begin
      wr8_n   <= wr8_n + 1;
      prev8   <= last8;
      last8   <= d8;
      wr8_cyc <= cyc;
    end
    if (pe8) pe8_n <= pe8_n + 1;
    if (fe8) fe8_n <= fe8_n + 1;
    if (ov8) ov8_n <= ov8_n + 1;
    if (bk8) bk8_n <= bk8_n + 1;
    if (wr7) begin
      wr7_n <= wr7_n + 1;
      last7 <= d7;
    end
    if (wr7 && pe7) pe7_wr_n <= pe7_wr_n + 1;
    if (fe7 || ov7 || bk7) err7_n <= err7_n + 1;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input int sel, input logic v);
    if (sel == 8) rx8 = v;
    else rx7 = v;
  endtask

  // Frame is LSB-first on the line; gbit selects a bit carrying a 10-clk inverted pulse.
  task automatic send(input int sel, input logic [11:0] frame, input int nbits, input int gbit);
    for (int b = 0; b < nbits; b++) begin
      drive(sel, frame[b]);
      if (b == gbit) begin
        idle(85);
        drive(sel, ~frame[b]);
        idle(10);
        drive(sel, frame[b]);
        idle(BIT_CLKS - 95);
      end else begin
        idle(BIT_CLKS);
      end
    end
    drive(sel, 1'b1);
  endtask

  function automatic logic [11:0] fr8(input logic [7:0] data, input logic stop);
    return {2'b11, stop, data, 1'b0};
  endfunction

  int s_wr, s_pe, s_fe, s_ov, s_bk, n0, t_first;

  initial begin
    idle(5);
    check("reset_out8", {wr8, pe8, fe8, ov8, bk8, d8}, 0);
    check("reset_out7", {wr7, pe7, fe7, ov7, bk7, d7}, 0);
    rst = 1'b0;
    idle(20);

    // Back-to-back 0xA5, 0x3C on 8N1
    s_wr = wr8_n; s_pe = pe8_n; s_fe = fe8_n; s_ov = ov8_n; s_bk = bk8_n;
    n0 = cyc;
    send(8, fr8(8'hA5, 1'b1), 10, -1);
    t_first = wr8_cyc;
    send(8, fr8(8'h3C, 1'b1), 10, -1);
    idle(40);
    check("b2b_count", wr8_n - s_wr, 2);
    check("b2b_first", prev8, 8'hA5);
    check("b2b_second", last8, 8'h3C);
    check("b2b_errs", (pe8_n - s_pe) + (fe8_n - s_fe) + (ov8_n - s_ov) + (bk8_n - s_bk), 0);
    check("b2b_latency", (t_first - n0 >= 1541) && (t_first - n0 <= 1546), 1);

    // 7E1: 0x41 has even weight, so a parity bit of 1 is wrong
    send(7, {2'b11, 1'b1, 1'b1, 7'h41, 1'b0}, 10, -1);
    idle(40);
    check("e71_wr", wr7_n, 1);
    check("e71_data", last7, 7'h41);
    check("e71_perr_with_wr", pe7_wr_n, 1);
    check("e71_other_errs", err7_n, 0);

    // Framing error then clean character
    s_wr = wr8_n; s_fe = fe8_n; s_bk = bk8_n;
    send(8, fr8(8'h55, 1'b0), 10, -1);
    check("fe_no_wr", wr8_n - s_wr, 0);
    idle(BIT_CLKS);
    send(8, fr8(8'h12, 1'b1), 10, -1);
    idle(40);
    check("fe_pulse", fe8_n - s_fe, 1);
    check("fe_next_wr", wr8_n - s_wr, 1);
    check("fe_next_data", last8, 8'h12);

    // Break: 20 bit times low
    s_wr = wr8_n; s_fe = fe8_n; s_bk = bk8_n;
    rx8 = 1'b0;
    idle(20 * BIT_CLKS);
    rx8 = 1'b1;
    idle(2 * BIT_CLKS);
    check("brk_pulse", bk8_n - s_bk, 1);
    check("brk_no_wr", wr8_n - s_wr, 0);
    check("brk_no_fe", fe8_n - s_fe, 0);
    send(8, fr8(8'h7E, 1'b1), 10, -1);
    idle(40);
    check("brk_next_data", last8, 8'h7E);

    // 3-clk glitch on idle line
    s_wr = wr8_n; s_pe = pe8_n; s_fe = fe8_n; s_ov = ov8_n; s_bk = bk8_n;
    rx8 = 1'b0;
    idle(3);
    rx8 = 1'b1;
    idle(3 * BIT_CLKS);
    check("glitch_idle", (wr8_n - s_wr) + (pe8_n - s_pe) + (fe8_n - s_fe) + (ov8_n - s_ov) + (bk8_n - s_bk), 0);

    // One-tick glitch mid data bit 3 of 0x00 (frame bit 4)
    s_wr = wr8_n;
    send(8, fr8(8'h00, 1'b1), 10, 4);
    idle(40);
    check("vote_wr", wr8_n - s_wr, 1);
    check("vote_data", last8, 8'h00);

    // Overrun with FIFO full
    s_wr = wr8_n; s_ov = ov8_n;
    full8 = 1'b1;
    send(8, fr8(8'h99, 1'b1), 10, -1);
    idle(40);
    full8 = 1'b0;
    check("ovr_pulse", ov8_n - s_ov, 1);
    check("ovr_no_wr", wr8_n - s_wr, 0);

    // Reset in the middle of a character
    s_wr = wr8_n; s_pe = pe8_n; s_fe = fe8_n; s_ov = ov8_n; s_bk = bk8_n;
    rx8 = 1'b0;
    idle(4 * BIT_CLKS);
    rst = 1'b1;
    idle(3);
    check("rst_mid_out", {wr8, pe8, fe8, ov8, bk8, d8}, 0);
    rx8 = 1'b1;
    idle(5);
    rst = 1'b0;
    idle(2 * BIT_CLKS);
    send(8, fr8(8'hC3, 1'b1), 10, -1);
    idle(40);
    check("rst_next_wr", wr8_n - s_wr, 1);
    check("rst_next_data", last8, 8'hC3);
    check("rst_errs", (pe8_n - s_pe) + (fe8_n - s_fe) + (ov8_n - s_ov) + (bk8_n - s_bk), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
